// File: rtl/rv_mem_pkg.sv
// rtl/rv_mem_pkg.sv - shared funct3 encodings, fill states and lane helpers
package rv_mem_pkg;

  // Load encodings (RISC-V funct3)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Store encodings (RISC-V funct3)
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  // Post-reset zero-fill sequencer states
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } fill_state_t;

  // Number of byte lanes in one XLEN-bit word
  function automatic int lane_count(input int xlen);
    return xlen / 8;
  endfunction

endpackage

// File: rtl/wb_dual_port_ram_if.sv
// rtl/wb_dual_port_ram_if.sv - data and fetch port bundle with master/slave views
interface wb_dual_port_ram_if #(
  parameter int XLEN = 32
);

  logic            i_wb_stb;
  logic            i_wb_we;
  logic [XLEN-1:0] i_addr;
  logic [XLEN-1:0] i_data;
  logic [2:0]      i_wb_sel;
  logic [XLEN-1:0] o_wb_data;
  logic            o_wb_ack;
  logic            o_wb_err;
  logic            o_wb_stall;
  logic            i_ib_stb;
  logic [XLEN-1:0] i_ib_addr;
  logic [31:0]     o_ib_data;
  logic            o_ib_ack;
  logic            o_ib_err;

  modport master (
    output i_wb_stb, i_wb_we, i_addr, i_data, i_wb_sel, i_ib_stb, i_ib_addr,
    input  o_wb_data, o_wb_ack, o_wb_err, o_wb_stall, o_ib_data, o_ib_ack, o_ib_err
  );

  modport slave (
    input  i_wb_stb, i_wb_we, i_addr, i_data, i_wb_sel, i_ib_stb, i_ib_addr,
    output o_wb_data, o_wb_ack, o_wb_err, o_wb_stall, o_ib_data, o_ib_ack, o_ib_err
  );

endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane enables, store shifting and load extension
module mem_lane_align
  import rv_mem_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int LANES = XLEN / 8,
  localparam int OFF_W = $clog2(LANES)
) (
  input  logic [2:0]       sel,
  input  logic [OFF_W-1:0] off,
  input  logic [XLEN-1:0]  st_data,
  input  logic [XLEN-1:0]  ld_word,
  output logic [LANES-1:0] be,
  output logic [XLEN-1:0]  st_word,
  output logic [XLEN-1:0]  ld_data
);

  logic [LANES-1:0] size_mask;
  logic [XLEN-1:0]  ld_shifted;

  // Place store bytes on their lanes and pull load bytes down to bit 0 with extension
  always_comb begin
    case (sel[1:0])
      2'd0:    size_mask = LANES'(1);
      2'd1:    size_mask = LANES'(3);
      2'd2:    size_mask = LANES'(15);
      default: size_mask = '1;
    endcase
    be         = size_mask << off;
    st_word    = st_data << {off, 3'b000};
    ld_shifted = ld_word >> {off, 3'b000};
    case (sel)
      F3_LB:   ld_data = XLEN'($signed(ld_shifted[7:0]));
      F3_LH:   ld_data = XLEN'($signed(ld_shifted[15:0]));
      F3_LW:   ld_data = XLEN'($signed(ld_shifted[31:0]));
      F3_LBU:  ld_data = XLEN'(ld_shifted[7:0]);
      F3_LHU:  ld_data = XLEN'(ld_shifted[15:0]);
      F3_LWU:  ld_data = XLEN'(ld_shifted[31:0]);
      default: ld_data = ld_shifted;
    endcase
  end

endmodule

// File: rtl/wb_dual_port_ram.sv
// rtl/wb_dual_port_ram.sv - pipelined data port plus read-only fetch port over one BRAM
module wb_dual_port_ram
  import rv_mem_pkg::*;
#(
  parameter int    XLEN         = 32,
  parameter int    DEPTH_WORDS  = 1024,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input logic              i_clk,
  input logic              i_reset,
  wb_dual_port_ram_if.slave bus
);

  localparam int LANES     = lane_count(XLEN);
  localparam int OFF_W     = $clog2(LANES);
  localparam int IDX_W     = $clog2(DEPTH_WORDS);
  localparam bit ZERO_FILL = (INIT_FILE == "");

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  fill_state_t      state;
  logic [IDX_W-1:0] fill_cnt;
  logic             stall_q;

  logic [OFF_W-1:0] wb_off;
  logic [IDX_W-1:0] wb_idx;
  logic [IDX_W-1:0] ib_idx;
  logic             wb_oor;
  logic             ib_oor;
  logic             ld_ok;
  logic             st_ok;
  logic             misalign;
  logic             wb_bad;
  logic             ib_bad;
  logic             wb_acc;
  logic             wb_store;

  logic [LANES-1:0] st_be;
  logic [XLEN-1:0]  st_word;
  logic [XLEN-1:0]  ld_data;
  logic [XLEN-1:0]  unused_wr_ld;
  logic [LANES-1:0] unused_rd_be;
  logic [XLEN-1:0]  unused_rd_st;

  // Acceptance-stage registers, shared by every latency setting
  logic             s0_ack;
  logic             s0_err;
  logic             s0_load;
  logic [2:0]       s0_sel;
  logic [OFF_W-1:0] s0_off;
  logic [XLEN-1:0]  s0_word;
  logic             f0_ack;
  logic             f0_err;
  logic             f0_half;
  logic [XLEN-1:0]  f0_word;
  logic [XLEN-1:0]  s0_data;
  logic [31:0]      f0_data;

  assign wb_off = bus.i_addr[OFF_W-1:0];
  assign wb_idx = bus.i_addr[OFF_W +: IDX_W];
  assign ib_idx = bus.i_ib_addr[OFF_W +: IDX_W];
  assign wb_oor = (bus.i_addr >> (OFF_W + IDX_W)) != '0;
  assign ib_oor = (bus.i_ib_addr >> (OFF_W + IDX_W)) != '0;

  // Decide whether the data-port request is legal for its direction, size and address
  always_comb begin
    ld_ok = 1'b0;
    st_ok = 1'b0;
    case (bus.i_wb_sel)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ld_ok = 1'b1;
      F3_LD, F3_LWU:                       ld_ok = (XLEN == 64);
      default:                             ld_ok = 1'b0;
    endcase
    case (bus.i_wb_sel)
      F3_SB, F3_SH, F3_SW: st_ok = 1'b1;
      F3_SD:               st_ok = (XLEN == 64);
      default:             st_ok = 1'b0;
    endcase
    misalign = (wb_off & OFF_W'((1 << bus.i_wb_sel[1:0]) - 1)) != '0;
    wb_bad   = !(bus.i_wb_we ? st_ok : ld_ok) || misalign || wb_oor;
  end

  assign wb_acc   = bus.i_wb_stb && !stall_q;
  assign wb_store = wb_acc && bus.i_wb_we && !wb_bad;
  assign ib_bad   = (bus.i_ib_addr[1:0] != 2'b00) || ib_oor || (state == CLEAR);

  mem_lane_align #(.XLEN(XLEN)) u_wr_align (
    .sel     (bus.i_wb_sel),
    .off     (wb_off),
    .st_data (bus.i_data),
    .ld_word ('0),
    .be      (st_be),
    .st_word (st_word),
    .ld_data (unused_wr_ld)
  );

  mem_lane_align #(.XLEN(XLEN)) u_rd_align (
    .sel     (s0_sel),
    .off     (s0_off),
    .st_data ('0),
    .ld_word (s0_word),
    .be      (unused_rd_be),
    .st_word (unused_rd_st),
    .ld_data (ld_data)
  );

  // Zero-fill sequencer: one word per cycle after reset, data port stalled until done
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= ZERO_FILL ? CLEAR : READY;
      fill_cnt <= '0;
      stall_q  <= ZERO_FILL;
    end else begin
      case (state)
        CLEAR: begin
          if (fill_cnt == IDX_W'(DEPTH_WORDS - 1)) begin
            state   <= READY;
            stall_q <= 1'b0;
          end else begin
            fill_cnt <= fill_cnt + 1'b1;
          end
        end
        default: begin
          state   <= READY;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  // BRAM: fill or lane-masked store, synchronous reads see the pre-write contents
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      if (state == CLEAR) begin
        mem[fill_cnt] <= '0;
      end else if (wb_store) begin
        for (int b = 0; b < LANES; b++) begin
          if (st_be[b]) begin
            mem[wb_idx][8*b +: 8] <= st_word[8*b +: 8];
          end
        end
      end
    end
    s0_word <= mem[wb_idx];
    f0_word <= mem[ib_idx];
  end

  // Capture request attributes at the acceptance edge for both ports
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s0_ack  <= 1'b0;
      s0_err  <= 1'b0;
      s0_load <= 1'b0;
      s0_sel  <= '0;
      s0_off  <= '0;
      f0_ack  <= 1'b0;
      f0_err  <= 1'b0;
      f0_half <= 1'b0;
    end else begin
      s0_ack  <= wb_acc;
      s0_err  <= wb_acc && wb_bad;
      s0_load <= !bus.i_wb_we;
      s0_sel  <= bus.i_wb_sel;
      s0_off  <= wb_off;
      f0_ack  <= bus.i_ib_stb;
      f0_err  <= bus.i_ib_stb && ib_bad;
      f0_half <= (XLEN == 64) ? bus.i_ib_addr[2] : 1'b0;
    end
  end

  assign s0_data = (s0_ack && s0_load && !s0_err) ? ld_data : '0;
  assign f0_data = (f0_ack && !f0_err) ? 32'(f0_word >> {f0_half, 5'b00000}) : 32'h0;

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign bus.o_wb_ack  = s0_ack;
      assign bus.o_wb_err  = s0_err;
      assign bus.o_wb_data = s0_data;
      assign bus.o_ib_ack  = f0_ack;
      assign bus.o_ib_err  = f0_err;
      assign bus.o_ib_data = f0_data;
    end else begin : g_latn
      localparam int DLY = READ_LATENCY - 1;
      logic            d_wb_ack  [DLY];
      logic            d_wb_err  [DLY];
      logic [XLEN-1:0] d_wb_data [DLY];
      logic            d_ib_ack  [DLY];
      logic            d_ib_err  [DLY];
      logic [31:0]     d_ib_data [DLY];

      // Extra response delay; reset drops every response still in flight
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          for (int i = 0; i < DLY; i++) begin
            d_wb_ack[i]  <= 1'b0;
            d_wb_err[i]  <= 1'b0;
            d_wb_data[i] <= '0;
            d_ib_ack[i]  <= 1'b0;
            d_ib_err[i]  <= 1'b0;
            d_ib_data[i] <= '0;
          end
        end else begin
          for (int i = DLY - 1; i > 0; i--) begin
            d_wb_ack[i]  <= d_wb_ack[i-1];
            d_wb_err[i]  <= d_wb_err[i-1];
            d_wb_data[i] <= d_wb_data[i-1];
            d_ib_ack[i]  <= d_ib_ack[i-1];
            d_ib_err[i]  <= d_ib_err[i-1];
            d_ib_data[i] <= d_ib_data[i-1];
          end
          d_wb_ack[0]  <= s0_ack;
          d_wb_err[0]  <= s0_err;
          d_wb_data[0] <= s0_data;
          d_ib_ack[0]  <= f0_ack;
          d_ib_err[0]  <= f0_err;
          d_ib_data[0] <= f0_data;
        end
      end

      assign bus.o_wb_ack  = d_wb_ack[DLY-1];
      assign bus.o_wb_err  = d_wb_err[DLY-1];
      assign bus.o_wb_data = d_wb_data[DLY-1];
      assign bus.o_ib_ack  = d_ib_ack[DLY-1];
      assign bus.o_ib_err  = d_ib_err[DLY-1];
      assign bus.o_ib_data = d_ib_data[DLY-1];
    end
  endgenerate

  assign bus.o_wb_stall = stall_q;

endmodule

// File: tb/tb_wb_dual_port_ram.sv
// tb/tb_wb_dual_port_ram.sv - randomized scoreboard bench for wb_dual_port_ram
module tb_wb_dual_port_ram;

  localparam int XLEN  = 32;
  localparam int DEPTH = 16;
  localparam int LAT   = 3;
  localparam int BYTES = DEPTH * 4;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SW = 3'b010;

  typedef struct {
    int          cyc;
    bit          err;
    logic [31:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  resp_t       exp_wb[$];
  resp_t       exp_ib[$];
  logic [7:0]  ref_mem [BYTES];
  bit          model_clear;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wb_dual_port_ram_if #(.XLEN(XLEN)) bus ();

  wb_dual_port_ram #(
    .XLEN(XLEN), .DEPTH_WORDS(DEPTH), .READ_LATENCY(LAT), .INIT_FILE("")
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .bus(bus)
  );

  // Scoreboard: every ack must match the next expected response, in order and on its cycle
  always @(negedge clk) begin
    resp_t e;
    checks++;
    if (bus.o_wb_ack !== 1'b1 && (bus.o_wb_err !== 1'b0 || bus.o_wb_data !== 32'h0)) begin
      errors++;
      $display("FAIL wb_idle cyc=%0d got err=%b data=%08h required err=0 data=00000000", cyc, bus.o_wb_err, bus.o_wb_data);
    end
    checks++;
    if (bus.o_ib_ack !== 1'b1 && (bus.o_ib_err !== 1'b0 || bus.o_ib_data !== 32'h0)) begin
      errors++;
      $display("FAIL ib_idle cyc=%0d got err=%b data=%08h required err=0 data=00000000", cyc, bus.o_ib_err, bus.o_ib_data);
    end
    if (bus.o_wb_ack === 1'b1) begin
      checks++;
      if (exp_wb.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected_ack cyc=%0d got err=%b data=%08h required no ack", cyc, bus.o_wb_err, bus.o_wb_data);
      end else begin
        e = exp_wb.pop_front();
        if (e.cyc !== cyc || e.err !== bus.o_wb_err || e.data !== bus.o_wb_data) begin
          errors++;
          $display("FAIL wb_ack got cyc=%0d err=%b data=%08h required cyc=%0d err=%b data=%08h",
                   cyc, bus.o_wb_err, bus.o_wb_data, e.cyc, e.err, e.data);
        end
      end
    end else if (exp_wb.size() > 0 && exp_wb[0].cyc <= cyc) begin
      checks++;
      errors++;
      e = exp_wb.pop_front();
      $display("FAIL wb_missing_ack cyc=%0d got no ack required err=%b data=%08h", cyc, e.err, e.data);
    end
    if (bus.o_ib_ack === 1'b1) begin
      checks++;
      if (exp_ib.size() == 0) begin
        errors++;
        $display("FAIL ib_unexpected_ack cyc=%0d got err=%b data=%08h required no ack", cyc, bus.o_ib_err, bus.o_ib_data);
      end else begin
        e = exp_ib.pop_front();
        if (e.cyc !== cyc || e.err !== bus.o_ib_err || e.data !== bus.o_ib_data) begin
          errors++;
          $display("FAIL ib_ack got cyc=%0d err=%b data=%08h required cyc=%0d err=%b data=%08h",
                   cyc, bus.o_ib_err, bus.o_ib_data, e.cyc, e.err, e.data);
        end
      end
    end else if (exp_ib.size() > 0 && exp_ib[0].cyc <= cyc) begin
      checks++;
      errors++;
      e = exp_ib.pop_front();
      $display("FAIL ib_missing_ack cyc=%0d got no ack required err=%b data=%08h", cyc, e.err, e.data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference data port: byte-addressed memory, size from funct3, sign from funct3[2]
  function automatic void model_wb(input bit we, input logic [2:0] sel, input logic [31:0] addr,
                                   input logic [31:0] data, output bit err, output logic [31:0] rd);
    int size;
    bit valid;
    size  = 1 << sel[1:0];
    valid = we ? (sel inside {3'b000, 3'b001, 3'b010}) : (sel inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    err   = !valid || (addr % size) != 0 || addr >= BYTES;
    rd    = 32'h0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < size; i++) ref_mem[addr + i] = data[8*i +: 8];
    end else begin
      for (int i = 0; i < size; i++) rd = rd | (32'(ref_mem[addr + i]) << (8 * i));
      if (!sel[2] && size < 4 && rd[8*size-1]) rd = rd | (32'hFFFF_FFFF << (8 * size));
    end
  endfunction

  function automatic void model_ib(input logic [31:0] addr, output bit err, output logic [31:0] rd);
    err = model_clear || addr[1:0] != 2'b00 || addr >= BYTES;
    rd  = 32'h0;
    if (!err) for (int i = 0; i < 4; i++) rd = rd | (32'(ref_mem[addr + i]) << (8 * i));
  endfunction

  // Present one cycle of requests; fetch is modelled before the store (read-before-write)
  task automatic req(input bit wb_en, input bit we, input logic [2:0] sel, input logic [31:0] addr,
                     input logic [31:0] data, input bit ib_en, input logic [31:0] ib_addr);
    resp_t r;
    bit e;
    logic [31:0] d;
    if (ib_en) begin
      model_ib(ib_addr, e, d);
      r.cyc = cyc + LAT; r.err = e; r.data = d;
      exp_ib.push_back(r);
    end
    if (wb_en) begin
      model_wb(we, sel, addr, data, e, d);
      r.cyc = cyc + LAT; r.err = e; r.data = d;
      exp_wb.push_back(r);
    end
    bus.i_wb_stb  = wb_en;
    bus.i_wb_we   = we;
    bus.i_wb_sel  = sel;
    bus.i_addr    = addr;
    bus.i_data    = data;
    bus.i_ib_stb  = ib_en;
    bus.i_ib_addr = ib_addr;
    tick();
  endtask

  task automatic idle();
    bus.i_wb_stb = 1'b0;
    bus.i_ib_stb = 1'b0;
    tick();
  endtask

  task automatic drain();
    repeat (LAT + 2) idle();
  endtask

  task automatic test_reset();
    int n;
    bus.i_wb_stb = 1'b0; bus.i_wb_we = 1'b0; bus.i_wb_sel = 3'b0; bus.i_addr = '0;
    bus.i_data = '0; bus.i_ib_stb = 1'b0; bus.i_ib_addr = '0;
    for (int i = 0; i < BYTES; i++) ref_mem[i] = 8'h00;
    model_clear = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.o_wb_stall !== 1'b1) begin errors++; $display("FAIL reset_stall got %b required 1", bus.o_wb_stall); end
    checks++;
    if ({bus.o_wb_ack, bus.o_wb_err, bus.o_ib_ack, bus.o_ib_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b required 0000", {bus.o_wb_ack, bus.o_wb_err, bus.o_ib_ack, bus.o_ib_err});
    end
    checks++;
    if (bus.o_wb_data !== 32'h0 || bus.o_ib_data !== 32'h0) begin
      errors++; $display("FAIL reset_data got %08h/%08h required 00000000/00000000", bus.o_wb_data, bus.o_ib_data);
    end
    rst = 1'b0;
    n = 0;
    while (bus.o_wb_stall === 1'b1 && n < 100) begin n++; tick(); end
    checks++;
    if (n != DEPTH) begin errors++; $display("FAIL clear_duration got %0d cycles required %0d", n, DEPTH); end
    model_clear = 1'b0;
  endtask

  task automatic test_zero_fill();
    req(1, 0, LW, 32'h3C, 0, 0, 0);
    req(1, 0, LW, 32'h00, 0, 1, 32'h20);
    drain();
  endtask

  task automatic test_sub_word();
    req(1, 1, SW,  32'h08, 32'h80FF7F01, 0, 0);
    req(1, 0, LB,  32'h08, 0, 0, 0);
    req(1, 0, LB,  32'h0B, 0, 0, 0);
    req(1, 0, LBU, 32'h0B, 0, 0, 0);
    req(1, 0, LH,  32'h0A, 0, 0, 0);
    req(1, 0, LHU, 32'h0A, 0, 1, 32'h08);
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      req(1, 1'($urandom % 2), LW, 32'($urandom_range(0, DEPTH - 1) * 4), $urandom, 0, 0);
    end
    for (int i = 0; i < 4; i++) req(1, 0, LW, 32'(i * 4), 0, 1, 32'(i * 4));
    drain();
  endtask

  task automatic test_errors();
    req(1, 1, SW,     32'h00, 32'hA5A5_5A5A, 0, 0);
    req(1, 0, LH,     32'h01, 0, 0, 0);
    req(1, 1, SW,     32'h02, 32'h1111_2222, 0, 0);
    req(1, 0, 3'b111, 32'h00, 0, 0, 0);
    req(1, 1, 3'b100, 32'h00, 32'hFFFF_FFFF, 0, 0);
    req(1, 1, SB,     32'(BYTES), 32'h77, 0, 0);
    req(1, 0, LW,     32'(BYTES), 0, 0, 0);
    req(1, 0, LW,     32'h00, 0, 0, 0);
    drain();
  endtask

  task automatic test_collision();
    req(1, 1, SW, 32'h10, 32'h0000_0013, 0, 0);
    req(1, 1, SW, 32'h10, 32'hDEAD_BEEF, 1, 32'h10);
    req(0, 0, LW, 0, 0, 1, 32'h10);
    req(0, 0, LW, 0, 0, 1, 32'h12);
    req(0, 0, LW, 0, 0, 1, 32'(BYTES));
    drain();
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] fa;
    for (int i = 0; i < 200; i++) begin
      a  = 32'($urandom_range(0, BYTES + 7));
      fa = 32'($urandom_range(0, BYTES + 7));
      if ($urandom % 2) a = a & ~32'h3;
      if ($urandom % 4 != 0) fa = fa & ~32'h3;
      req(1'($urandom % 4 != 0), 1'($urandom % 2), 3'($urandom_range(0, 7)), a, $urandom,
          1'($urandom % 2), fa);
      if ($urandom % 5 == 0) idle();
    end
    drain();
  endtask

  task automatic test_reset_flush();
    int n;
    req(1, 1, SW, 32'h08, 32'h1234_5678, 0, 0);
    drain();
    req(1, 0, LW, 32'h08, 0, 0, 0);
    req(1, 0, LW, 32'h10, 0, 0, 0);
    bus.i_wb_stb = 1'b0;
    bus.i_ib_stb = 1'b0;
    rst = 1'b1;
    exp_wb.delete();
    exp_ib.delete();
    model_clear = 1'b1;
    for (int i = 0; i < BYTES; i++) ref_mem[i] = 8'h00;
    repeat (2) tick();
    checks++;
    if (bus.o_wb_ack !== 1'b0 || bus.o_wb_stall !== 1'b1) begin
      errors++; $display("FAIL flush_in_reset got ack=%b stall=%b required ack=0 stall=1", bus.o_wb_ack, bus.o_wb_stall);
    end
    rst = 1'b0;
    checks++;
    if (bus.o_wb_stall !== 1'b1) begin errors++; $display("FAIL flush_stall got %b required 1", bus.o_wb_stall); end
    n = 1;
    req(0, 0, LW, 0, 0, 1, 32'h08);
    bus.i_ib_stb = 1'b0;
    while (bus.o_wb_stall === 1'b1 && n < 100) begin n++; tick(); end
    checks++;
    if (n != DEPTH) begin errors++; $display("FAIL reclear_duration got %0d cycles required %0d", n, DEPTH); end
    model_clear = 1'b0;
    req(1, 0, LW, 32'h08, 0, 1, 32'h08);
    req(1, 0, LW, 32'h00, 0, 0, 0);
    drain();
  endtask

  initial begin
    test_reset();
    test_zero_fill();
    test_sub_word();
    test_back_to_back();
    test_errors();
    test_collision();
    test_random();
    test_reset_flush();
    checks++;
    if (exp_wb.size() != 0 || exp_ib.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got %0d/%0d pending required 0/0", exp_wb.size(), exp_ib.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_dual_port_ram.md
Name: wb_dual_port_ram

Overview:
Parametrised successor to the single-port FPGA block RAM. It provides a Wishbone-pipelined data port with RISC-V funct3-encoded sub-word access, sign/zero extension and error signalling. A second read-only instruction-fetch port is added, along with a configurable read latency and a post-reset zero-fill sequencer. It sits between hart data/fetch interfaces and FPGA BRAM.

Parameters:
XLEN, 32, data/address width; 32 or 64 only.
DEPTH_WORDS, 1024, number of XLEN-bit words; power of two.
READ_LATENCY, 1, cycles from accepted strobe to ack on both ports; 1..4.
INIT_FILE, "", hex image loaded by $readmemh; empty selects zero-fill after reset.

Ports:
i_clk  in  1  clock
i_reset  in  1  reset, asynchronous, active-high
i_wb_stb  in  1  data-port request strobe
i_wb_we  in  1  1 = store, 0 = load
i_addr  in  XLEN  data byte address
i_data  in  XLEN  store data, LSB-aligned
i_wb_sel  in  3  access size/sign, RISC-V funct3 encoding
o_wb_data  out  XLEN  load result, extended; 0 when o_wb_ack=0
o_wb_ack  out  1  data-port completion, one cycle per accepted request
o_wb_err  out  1  qualifies o_wb_ack: request rejected
o_wb_stall  out  1  data port cannot accept this cycle
i_ib_stb  in  1  fetch request strobe
i_ib_addr  in  XLEN  fetch byte address
o_ib_data  out  32  instruction word; 0 when o_ib_ack=0
o_ib_ack  out  1  fetch completion
o_ib_err  out  1  qualifies o_ib_ack: misaligned or out of range

Behaviour:
- Word index = addr[log2(XLEN/8) +: log2(DEPTH_WORDS)]. Any higher address bit set = out of range.
- Request accepted when stb=1 and stall=0. Ack (plus err, data) appears exactly READ_LATENCY cycles later. Back-to-back requests are fully pipelined, one per cycle.
- Writes take effect at the acceptance edge. They are acked with the same latency as loads; o_wb_data=0 on write acks.
- sel encodings. Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. With XLEN=64 also: 011 ld, 110 lwu. Stores: 000 sb, 001 sh, 010 sw, plus 011 sd with XLEN=64.
- Any other sel, misalignment (addr not a multiple of access size) or out-of-range gives an ack with err=1. No memory change; data=0.
- Stores use per-byte lane enables and never modify unselected bytes.
- Fetch port: fixed 32-bit read. Error if i_ib_addr[1:0]!=0 or out of range. For XLEN=64, the half is selected by addr[2].
- Same-word collision (data store and fetch in the same cycle): fetch returns the old contents (read-before-write).
- Zero-fill FSM, states CLEAR and READY:
  - Reset enters CLEAR if INIT_FILE=="", else READY.
  - CLEAR writes 0 to one word per cycle, counter 0..DEPTH_WORDS-1, then goes to READY. Duration is exactly DEPTH_WORDS cycles after reset release.
  - o_wb_stall=1 in CLEAR. Fetch strobes in CLEAR get ack with err=1 at normal latency.
  - In READY, o_wb_stall=0.
- Reset values: o_wb_ack, o_wb_err, o_ib_ack, o_ib_err, o_wb_data, o_ib_data all 0. o_wb_stall=1 if CLEAR, else 0.
- Reset mid-operation flushes all in-flight acks (none emitted afterwards) and restarts CLEAR from word 0. Memory contents are not reset asynchronously.
- Strobes while i_reset=1 are ignored.

Decomposition:
- Shared package rv_mem_pkg holds:
  - funct3 access encodings (LB, LH, LW, LD, LBU, LHU, LWU and store equivalents);
  - fill-FSM state enum {CLEAR, READY};
  - helper constants for the lane count XLEN/8.
- One combinational sub-module, mem_lane_align, builds the store byte-enable and shifted data, and the load lane extraction with sign/zero extension. It is instantiated once per use, for the write path and the read path.

Test Plan:
- INIT_FILE="", DEPTH_WORDS=16, release reset -> o_wb_stall=1 for exactly 16 cycles. Subsequent lw at 0x3C -> data 0x00000000, err=0.
- sw 0x80FF7F01 @0x8, then lb @0x8 / lb @0xB / lbu @0xB / lh @0xA -> 0x00000001 / 0xFFFFFF80 / 0x00000080 / 0xFFFF80FF.
- READ_LATENCY=3, stores/loads issued on 4 consecutive cycles -> 4 consecutive acks, the first exactly 3 cycles after the first strobe, in order.
- lh @0x1, sw @0x2, sel=111, lw @(DEPTH_WORDS*4) -> each acked with err=1, data 0; a later lw confirms memory unchanged.
- Same cycle: sw 0xDEADBEEF @0x10 and fetch @0x10 holding 0x00000013 -> fetch returns 0x00000013. The next fetch returns 0xDEADBEEF.
- Assert i_reset with 2 loads in flight -> no acks after reset. Stall=1 and CLEAR restarts at word 0.
